// File: rtl/dct8_1d_pipe.sv
// dct8_1d_pipe: streaming 8-point 1-D forward DCT, 5-stage pipeline with a global valid/ready stall.
// Optional macro DCT8_ROUND_EN: round-half-up in the output stage instead of floor.
module dct8_1d_pipe #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned ACC_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [8*IN_W-1:0]  in_data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [8*OUT_W-1:0] out_data_o,
    output logic               sat_flag_o
);
    localparam int unsigned SD_W  = IN_W + 1;
    localparam int unsigned SHIFT = 11;

    localparam logic signed [ACC_W-1:0] C1 = ACC_W'(1004);
    localparam logic signed [ACC_W-1:0] C2 = ACC_W'(946);
    localparam logic signed [ACC_W-1:0] C3 = ACC_W'(851);
    localparam logic signed [ACC_W-1:0] C4 = ACC_W'(724);
    localparam logic signed [ACC_W-1:0] C5 = ACC_W'(569);
    localparam logic signed [ACC_W-1:0] C6 = ACC_W'(392);
    localparam logic signed [ACC_W-1:0] C7 = ACC_W'(200);
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;
`ifdef DCT8_ROUND_EN
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(1024);
`endif

    logic                    en_c;
    logic [4:0]              v_q, v_d;
    logic signed [SD_W-1:0]  s_q  [4];
    logic signed [SD_W-1:0]  s_d  [4];
    logic signed [SD_W-1:0]  d_q  [4];
    logic signed [SD_W-1:0]  d_d  [4];
    logic signed [ACC_W-1:0] ps_q [12];
    logic signed [ACC_W-1:0] ps_d [12];
    logic signed [ACC_W-1:0] pd_q [16];
    logic signed [ACC_W-1:0] pd_d [16];
    logic signed [ACC_W-1:0] pr_q [16];
    logic signed [ACC_W-1:0] pr_d [16];
    logic signed [ACC_W-1:0] p_q  [8];
    logic signed [ACC_W-1:0] p_d  [8];
    logic signed [ACC_W-1:0] sh_c [8];
    logic [8*OUT_W-1:0]      out_q, out_d;
    logic                    sat_q, sat_d;

    // Whole pipeline moves only when the output register is free or being drained.
    assign en_c        = !v_q[4] || out_ready_i;
    assign in_ready_o  = en_c;
    assign out_valid_o = v_q[4];
    assign out_data_o  = out_q;
    assign sat_flag_o  = sat_q;
    assign v_d         = {v_q[3:0], in_valid_i};

    // S1: butterfly sums and differences
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            s_d[i] = SD_W'($signed(in_data_i[i*IN_W +: IN_W]))
                   + SD_W'($signed(in_data_i[(7-i)*IN_W +: IN_W]));
            d_d[i] = SD_W'($signed(in_data_i[i*IN_W +: IN_W]))
                   - SD_W'($signed(in_data_i[(7-i)*IN_W +: IN_W]));
        end
    end

    // S2: even products at [C4|C2|C6]*4+i, odd products at [C1|C3|C5|C7]*4+i
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ps_d[i]      = ACC_W'(s_q[i]) * C4;
            ps_d[4 + i]  = ACC_W'(s_q[i]) * C2;
            ps_d[8 + i]  = ACC_W'(s_q[i]) * C6;
            pd_d[i]      = ACC_W'(d_q[i]) * C1;
            pd_d[4 + i]  = ACC_W'(d_q[i]) * C3;
            pd_d[8 + i]  = ACC_W'(d_q[i]) * C5;
            pd_d[12 + i] = ACC_W'(d_q[i]) * C7;
        end
    end

    // S3: two partial sums per coefficient, Pk = pr[2k] + pr[2k+1]
    always_comb begin
        pr_d[0]  = ps_q[0] + ps_q[1];
        pr_d[1]  = ps_q[2] + ps_q[3];
        pr_d[2]  = pd_q[0] + pd_q[5];
        pr_d[3]  = pd_q[10] + pd_q[15];
        pr_d[4]  = ps_q[4] + ps_q[9];
        pr_d[5]  = -ps_q[10] - ps_q[7];
        pr_d[6]  = pd_q[4] - pd_q[13];
        pr_d[7]  = -pd_q[2] - pd_q[11];
        pr_d[8]  = ps_q[0] - ps_q[1];
        pr_d[9]  = ps_q[3] - ps_q[2];
        pr_d[10] = pd_q[8] - pd_q[1];
        pr_d[11] = pd_q[14] + pd_q[7];
        pr_d[12] = ps_q[8] - ps_q[5];
        pr_d[13] = ps_q[6] - ps_q[11];
        pr_d[14] = pd_q[12] - pd_q[9];
        pr_d[15] = pd_q[6] - pd_q[3];
    end

    // S4: final sums
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            p_d[k] = pr_q[2*k] + pr_q[2*k + 1];
        end
    end

    // S5: rescale and clip to the output range
    always_comb begin
        out_d = '0;
        sat_d = 1'b0;
        for (int k = 0; k < 8; k++) begin
`ifdef DCT8_ROUND_EN
            sh_c[k] = (p_q[k] + RND) >>> SHIFT;
`else
            sh_c[k] = p_q[k] >>> SHIFT;
`endif
            if (sh_c[k] > Y_MAX) begin
                out_d[k*OUT_W +: OUT_W] = Y_MAX[OUT_W-1:0];
                sat_d = 1'b1;
            end else if (sh_c[k] < Y_MIN) begin
                out_d[k*OUT_W +: OUT_W] = Y_MIN[OUT_W-1:0];
                sat_d = 1'b1;
            end else begin
                out_d[k*OUT_W +: OUT_W] = sh_c[k][OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            out_q <= '0;
            sat_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                s_q[i] <= '0;
                d_q[i] <= '0;
            end
            for (int i = 0; i < 12; i++) ps_q[i] <= '0;
            for (int i = 0; i < 16; i++) begin
                pd_q[i] <= '0;
                pr_q[i] <= '0;
            end
            for (int i = 0; i < 8; i++) p_q[i] <= '0;
        end else if (en_c) begin
            v_q   <= v_d;
            s_q   <= s_d;
            d_q   <= d_d;
            ps_q  <= ps_d;
            pd_q  <= pd_d;
            pr_q  <= pr_d;
            p_q   <= p_d;
            out_q <= out_d;
            sat_q <= sat_d;
        end
    end
endmodule
